// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals of the boot loader.
// The master side is the byte source plus memory observer; the slave
// side is the loader itself.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer. Takes a little-endian length header
// followed by the image bytes, assembles 32-bit words, writes them to
// consecutive word addresses and releases the core reset once the whole
// image is in memory. Every output is registered.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          done,
    output logic          error,
    output logic [31:0]   word_count,
    output logic [31:0]   checksum,
    output logic          cpu_rst_n
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] checksum_q, checksum_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;

    logic        xfer;
    logic        restart;
    logic [31:0] hdr_word;
    logic [31:0] data_word;

    // A byte moves only when the source offers it while the loader is ready.
    // The incoming byte always lands in the top lane, so after four bytes the
    // first one sits in bits 7:0.
    assign xfer      = bus.in_valid && in_ready_q;
    assign hdr_word  = {bus.in_data, word_count_q[31:8]};
    assign data_word = {bus.in_data, asm_q};
    assign restart   = start && (state_q == IDLE || state_q == DONE || state_q == ERR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-value logic for the whole loader. The last word of
    // the image drops in_ready at its own edge; DATA with in_ready low then
    // means "final word written", and the following edge enters DONE.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        in_ready_d   = in_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        error_d      = error_q;
        cpu_rst_n_d  = cpu_rst_n_q;

        if (restart) begin
            state_d      = LEN;
            byte_idx_d   = 2'd0;
            word_idx_d   = 32'd0;
            asm_d        = 24'd0;
            word_count_d = 32'd0;
            checksum_d   = 32'd0;
            in_ready_d   = 1'b1;
            done_d       = 1'b0;
            error_d      = 1'b0;
            cpu_rst_n_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_d = 1'b0;
                end
                LEN: begin
                    if (xfer) begin
                        byte_idx_d   = byte_idx_q + 2'd1;
                        word_count_d = hdr_word;
                        if (byte_idx_q == 2'd3) begin
                            if (hdr_word == 32'd0) begin
                                state_d    = DONE;
                                done_d     = 1'b1;
                                in_ready_d = 1'b0;
                            end else if (hdr_word > MAX_W) begin
                                state_d    = ERR;
                                error_d    = 1'b1;
                                in_ready_d = 1'b0;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (!in_ready_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (xfer) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        asm_d      = data_word[31:8];
                        if (byte_idx_q == 2'd3) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = data_word;
                            mem_addr_d  = BASE_ADDR + (word_idx_q << 2);
                            checksum_d  = checksum_q + data_word;
                            word_idx_d  = word_idx_q + 32'd1;
                            if (word_idx_q == word_count_q - 32'd1) begin
                                in_ready_d = 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    in_ready_d  = 1'b0;
                    cpu_rst_n_d = 1'b1;
                end
                ERR: begin
                    in_ready_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q   <= 2'd0;
            word_idx_q   <= 32'd0;
            asm_q        <= 24'd0;
            word_count_q <= 32'd0;
            checksum_q   <= 32'd0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= 32'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign done          = done_q;
    assign error         = error_q;
    assign word_count    = word_count_q;
    assign checksum      = checksum_q;
    assign cpu_rst_n     = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Images are built as byte queues and
// a queue-based reference model derives the expected writes, checksum and
// length from the byte stream alone.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;
    localparam logic [132:0] RST_VALS = {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done, error, cpu_rst_n;
    logic [31:0] word_count, checksum;

    imem_loader_if bus();

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .checksum   (checksum),
        .cpu_rst_n  (cpu_rst_n)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;
    int cycle = 0;
    always @(posedge clk) cycle++;

    int checks = 0;
    int fails  = 0;

    // Monitor: records every write and the first cycle done / cpu_rst_n rise.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc = -1;
    int          cpu_cyc  = -1;

    always @(posedge clk) begin
        #1;
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_cyc.push_back(cycle);
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cycle;
        if (cpu_rst_n === 1'b1 && cpu_cyc < 0) cpu_cyc = cycle;
    end

    // Image and reference model state.
    logic [7:0]  img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_n;
    logic [31:0] exp_sum;
    bit          exp_err;

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
        cpu_cyc  = -1;
    endtask

    task automatic make_image(input int n);
        logic [31:0] w;
        logic [31:0] nn;
        img.delete();
        nn = n;
        for (int b = 0; b < 4; b++) img.push_back(nn[8*b +: 8]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
        end
    endtask

    // Reference model: header is a LE word, words follow LE, addresses step by 4.
    task automatic build_model();
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_sum = 32'h0;
        exp_n   = {img[3], img[2], img[1], img[0]};
        exp_err = (exp_n > 32'(MAXW));
        if (!exp_err) begin
            for (int i = 0; i < int'(exp_n); i++) begin
                w = {img[4 + 4*i + 3], img[4 + 4*i + 2], img[4 + 4*i + 1], img[4 + 4*i]};
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back(w);
                exp_sum = exp_sum + w;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit with_start, output int acc_cyc);
        logic ok;
        int   gap;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (with_start) start = 1'b1;
        acc_cyc = -1;
        for (int k = 0; k < 50 && acc_cyc < 0; k++) begin
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ok) acc_cyc = cycle;
        end
        if (acc_cyc < 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL byte_accept: byte %h not accepted, got in_ready=%b, need 1", b, bus.in_ready);
        end
    endtask

    task automatic send_stream(input int maxgap, input int start_at, output int last_cyc);
        last_cyc = -1;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], maxgap, (i == start_at), last_cyc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        for (int k = 0; k < budget && cpu_cyc < 0 && error !== 1'b1; k++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [132:0] obs;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        obs = {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, error, word_count, checksum, cpu_rst_n};
        checks++;
        if (obs !== RST_VALS) begin
            fails++;
            $display("[TB] FAIL reset_values: got %h, need %h", obs, RST_VALS);
        end
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_ignores_valid: got ready=%b we=%b, need 0 0", bus.in_ready, bus.mem_we);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int last;
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_model();
        pulse_start();
        clear_mon();
        send_stream(0, -1, last);
        wait_finish(20);
        checks++;
        if (wr_addr.size() != 2) begin
            fails++;
            $display("[TB] FAIL basic_write_count: got %0d, need 2", wr_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                fails++;
                $display("[TB] FAIL basic_write%0d: got (%h,%h), need (%h,%h)", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (checksum !== 32'h001000A6 || word_count !== 32'd2) begin
            fails++;
            $display("[TB] FAIL basic_sum_len: got %h/%h, need 001000a6/00000002", checksum, word_count);
        end
        if (wr_cyc.size() == 2) begin
            checks++;
            if (wr_cyc[1] != last) begin
                fails++;
                $display("[TB] FAIL basic_we_latency: got cycle %0d, need %0d", wr_cyc[1], last);
            end
            checks++;
            if (done_cyc != wr_cyc[1] + 1) begin
                fails++;
                $display("[TB] FAIL basic_done_timing: got cycle %0d, need %0d", done_cyc, wr_cyc[1] + 1);
            end
        end
        checks++;
        if (cpu_cyc != done_cyc + 1 || done_cyc < 0) begin
            fails++;
            $display("[TB] FAIL basic_cpu_release: got cycle %0d, need %0d", cpu_cyc, done_cyc + 1);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_ready_after_done: got %b, need 0", bus.in_ready);
        end
    endtask

    task automatic test_zero_length();
        int last;
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        clear_mon();
        send_stream(0, -1, last);
        wait_finish(10);
        checks++;
        if (wr_addr.size() != 0 || word_count !== 32'd0 || checksum !== 32'd0) begin
            fails++;
            $display("[TB] FAIL zero_len: got writes=%0d len=%h sum=%h, need 0 0 0", wr_addr.size(), word_count, checksum);
        end
        checks++;
        if (done_cyc != last || cpu_cyc != last + 1) begin
            fails++;
            $display("[TB] FAIL zero_len_timing: got done@%0d cpu@%0d, need done@%0d cpu@%0d", done_cyc, cpu_cyc, last, last + 1);
        end
    endtask

    task automatic test_error();
        int last;
        img = '{8'h01, 8'h04, 8'h00, 8'h00};
        pulse_start();
        clear_mon();
        send_stream(0, -1, last);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0 || cpu_rst_n !== 1'b0 || wr_addr.size() != 0) begin
            fails++;
            $display("[TB] FAIL err_state: got err=%b done=%b rdy=%b cpu=%b writes=%0d, need 1 0 0 0 0",
                     error, done, bus.in_ready, cpu_rst_n, wr_addr.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_clear: got error=%b, need 0", error);
        end
        clear_mon();
        make_image(1);
        build_model();
        send_stream(0, -1, last);
        wait_finish(20);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== exp_addr[0] || wr_data[0] !== exp_data[0] ||
            done !== 1'b1 || cpu_rst_n !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_recover: got writes=%0d data=%h done=%b cpu=%b, need 1 %h 1 1",
                     wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0, done, cpu_rst_n, exp_data[0]);
        end
    endtask

    task automatic test_gaps();
        int last;
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        pulse_start();
        clear_mon();
        send_stream(3, -1, last);
        wait_finish(20);
        checks++;
        if (wr_addr.size() != 1) begin
            fails++;
            $display("[TB] FAIL gaps_count: got %0d writes, need 1", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== BASE || wr_data[0] !== 32'h12345678 || wr_cyc[0] != last) begin
                fails++;
                $display("[TB] FAIL gaps_write: got (%h,%h)@%0d, need (%h,12345678)@%0d", wr_addr[0], wr_data[0], wr_cyc[0], BASE, last);
            end
        end
    endtask

    task automatic test_reset_mid();
        int           last;
        logic [132:0] obs;
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD};
        pulse_start();
        clear_mon();
        send_stream(0, -1, last);
        #3;
        rst_n = 1'b0;
        #1;
        obs = {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, error, word_count, checksum, cpu_rst_n};
        checks++;
        if (obs !== RST_VALS) begin
            fails++;
            $display("[TB] FAIL midreset_values: got %h, need %h", obs, RST_VALS);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_addr.size() != 0) begin
            fails++;
            $display("[TB] FAIL midreset_no_write: got %0d writes, need 0", wr_addr.size());
        end
        pulse_start();
        clear_mon();
        make_image(1);
        build_model();
        send_stream(1, -1, last);
        wait_finish(20);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== BASE || wr_data[0] !== exp_data[0] || checksum !== exp_sum) begin
            fails++;
            $display("[TB] FAIL midreset_fresh: got writes=%0d data=%h sum=%h, need 1 %h %h",
                     wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0, checksum, exp_data[0], exp_sum);
        end
    endtask

    task automatic test_start_mid();
        int last;
        make_image(3);
        build_model();
        pulse_start();
        clear_mon();
        send_stream(1, 9, last);
        wait_finish(20);
        checks++;
        if (wr_addr.size() != 3 || word_count !== 32'd3 || checksum !== exp_sum || done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL startmid_summary: got writes=%0d len=%h sum=%h done=%b, need 3 3 %h 1",
                     wr_addr.size(), word_count, checksum, done, exp_sum);
        end
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                fails++;
                $display("[TB] FAIL startmid_write%0d: got (%h,%h), need (%h,%h)", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int bad;
        make_image(MAXW);
        build_model();
        pulse_start();
        clear_mon();
        send_stream(0, -1, last);
        wait_finish(20);
        checks++;
        if (wr_addr.size() != MAXW || checksum !== exp_sum || word_count !== 32'(MAXW)) begin
            fails++;
            $display("[TB] FAIL b2b_summary: got writes=%0d sum=%h len=%h, need %0d %h %h",
                     wr_addr.size(), checksum, word_count, MAXW, exp_sum, 32'(MAXW));
        end
        bad = 0;
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
            if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 4) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL b2b_writes: got %0d bad writes or spacings, need 0", bad);
        end
    endtask

    task automatic test_random();
        int last;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(6, 1));
            make_image(n);
            build_model();
            pulse_start();
            clear_mon();
            send_stream(int'($urandom_range(2, 0)), -1, last);
            wait_finish(20);
            checks++;
            if (wr_addr.size() != exp_addr.size() || checksum !== exp_sum || word_count !== exp_n ||
                done !== 1'b1 || cpu_rst_n !== 1'b1) begin
                fails++;
                $display("[TB] FAIL rand%0d_summary: got writes=%0d sum=%h len=%h done=%b cpu=%b, need %0d %h %h 1 1",
                         it, wr_addr.size(), checksum, word_count, done, cpu_rst_n, exp_addr.size(), exp_sum, exp_n);
            end
            for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
                checks++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_write%0d: got (%h,%h), need (%h,%h)", it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_zero_length();
        test_error();
        test_gaps();
        test_reset_mid();
        test_start_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer: accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them to consecutive instruction memory locations. It is the write-side counterpart of the instruction ROM fetch path. It holds the core in reset until the image is loaded, then releases it. It sits between the boot byte source (UART receiver or bench driver) and the instruction memory write port.

## Interface

- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- MAX_WORDS, 1024: largest accepted image length in words.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  byte source has a byte.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  32  byte address of the write, word aligned.
- mem_wdata  out  32  word to write.
- done  out  1  image fully written.
- error  out  1  length header exceeded MAX_WORDS.
- word_count  out  32  length header value N.
- checksum  out  32  sum of all written words, mod 2^32.
- cpu_rst_n  out  1  core reset, active low; released after done.

## Operation

- States: IDLE, LEN, DATA, DONE, ERR. Reset value of the state is IDLE.
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, error=0, word_count=0, checksum=0, cpu_rst_n=0.
- IDLE: in_ready=0. A start pulse moves the FSM to LEN and clears the byte index, the word index, word_count and checksum.
- LEN: in_ready=1. Accepts 4 bytes, least significant first, into word_count. On the 4th byte:
  - N==0: go to DONE.
  - N>MAX_WORDS: go to ERR.
  - otherwise: go to DATA.
- DATA: in_ready=1. Accepts bytes LS-first into a word assembler. On the 4th byte of word i, at the same edge:
  - mem_we<=1, mem_wdata<=assembled word, mem_addr<=BASE_ADDR+4*i;
  - checksum<=checksum+word;
  - word index increments.
- mem_we is high for exactly one cycle per word.
- After the final word (i==N-1), in_ready drops at that same edge. The FSM goes to DONE on the following edge.
- DONE: done=1, in_ready=0. cpu_rst_n goes high one edge after done rises and stays high until reset or a new start.
- ERR: error=1, in_ready=0, no writes, cpu_rst_n stays 0.
- start in LEN or DATA is ignored. start in DONE or ERR clears done, error and cpu_rst_n, then restarts at LEN.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no special handling. Byte and word indices reset on every start.
- in_valid with in_ready low is ignored. The source holds in_data until accepted.
- Asynchronous reset at any point, including mid-word or mid-header, returns every output to its reset value immediately. The partial word is discarded.

## Timing

- Latency is 1 cycle from acceptance of the 4th byte of a word to mem_we being visible.
- Back-to-back acceptance at one byte per cycle sustains 1 word per 4 cycles with no stall. The memory port is single-cycle write with no backpressure.
- Last word accepted at edge E: mem_we high in cycle E..E+1, done high from E+1, cpu_rst_n high from E+2.
- N==0, 4th header byte at edge E: done from E, cpu_rst_n from E+1.
- checksum and word_count are stable whenever done=1.

## Test plan

- Stream header 02 00 00 00 then bytes 13 00 00 00 93 00 10 00 with in_valid continuous. Required response:
  - writes (0x00, 0x00000013) and (0x04, 0x00100093);
  - checksum=0x001000A6;
  - done one cycle after the second mem_we;
  - cpu_rst_n one cycle later.
- Header 00 00 00 00: no mem_we, done after the 4th byte, word_count=0, checksum=0.
- Header equal to MAX_WORDS+1: error=1, no mem_we, in_ready=0, cpu_rst_n stays 0. A following start with a valid 1-word image clears error and completes.
- Random in_valid gaps during the 1-word image 78 56 34 12: a single write of 0x12345678 at BASE_ADDR. No write occurs while the word is incomplete.
- Assert rst_n=0 after 2 data bytes, then release and start a fresh 1-word image: the partial bytes never appear, the write lands at BASE_ADDR, and all outputs read reset values during reset.
- Pulse start mid-DATA: ignored. The load completes with the original N and addresses.
